// File: rtl/instr_encoder.sv
// instr_encoder
//   Takes RV32I field tuples (opcode, rd, rs1, rs2, funct3, funct7, imm) for a
//   subset of formats, packs each into a 32-bit instruction word, and hands the
//   words to an instruction-memory writer through a small FIFO. Each word is
//   tagged with a byte address that starts at BASE_ADDR for every load session
//   and advances by 4 for every word handed off.
//
//   Ports
//     clk, reset           clock, synchronous active-high reset
//     start                one-cycle pulse, opens a load session (IDLE only)
//     in_valid/in_ready    tuple handshake; in_last marks the final tuple
//     opcode..imm          tuple fields
//     out_valid/out_ready  encoded-word handshake
//     out_addr, out_data   byte address and encoding of the FIFO head word
//     err                  pulse the cycle after a tuple is rejected
//     err_count            saturating count of rejected tuples this session
//     word_count           words handed off this session (wraps)
//     done                 one-cycle pulse when the session completes
module instr_encoder #(
  parameter int          DEPTH     = 4,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [6:0]  opcode,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [2:0]  funct3,
  input  logic [6:0]  funct7,
  input  logic [31:0] imm,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_addr,
  output logic [31:0] out_data,
  output logic        err,
  output logic [7:0]  err_count,
  output logic [15:0] word_count,
  output logic        done
);

  localparam int AW = $clog2(DEPTH);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOAD  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [6:0] OP_R  = 7'b0110011;
  localparam logic [6:0] OP_I  = 7'b0010011;
  localparam logic [6:0] OP_LW = 7'b0000011;
  localparam logic [6:0] OP_SW = 7'b0100011;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A 12-bit signed immediate fits only when bits 31..11 are a pure sign extension.
  function automatic logic imm12_ok(input logic [31:0] v);
    return (&v[31:11]) || (~|v[31:11]);
  endfunction

  logic [1:0]    state_q, state_d;
  logic [AW-1:0] wptr_q, wptr_d, rptr_q, rptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   addr_q, addr_d;
  logic          err_q, err_d;
  logic [7:0]    err_count_q, err_count_d;
  logic [15:0]   word_count_q, word_count_d;
  logic [31:0]   mem [DEPTH];

  logic [31:0] enc_word;
  logic        enc_ok;
  logic        empty, full, accept, push, pop;

  always_comb begin
    enc_word = 32'h0;
    enc_ok   = 1'b0;
    case (opcode)
      OP_R: begin
        enc_word = {funct7, rs2, rs1, funct3, rd, opcode};
        enc_ok   = 1'b1;
      end
      OP_I, OP_LW: begin
        enc_word = {imm[11:0], rs1, funct3, rd, opcode};
        enc_ok   = imm12_ok(imm);
      end
      OP_SW: begin
        enc_word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
        enc_ok   = imm12_ok(imm);
      end
      default: ;
    endcase
  end

  assign empty = (cnt_q == '0);
  assign full  = (cnt_q == (AW+1)'(DEPTH));

  // Outputs are held at their reset values for the whole reset cycle so that
  // no handshake can complete while reset is asserted.
  assign in_ready   = !reset && (state_q == S_LOAD) && !full;
  assign out_valid  = !reset && !empty;
  assign out_addr   = reset ? BASE_ADDR : addr_q;
  assign out_data   = out_valid ? mem[rptr_q] : 32'h0;
  assign err        = !reset && err_q;
  assign err_count  = reset ? 8'h0 : err_count_q;
  assign word_count = reset ? 16'h0 : word_count_q;
  assign done       = !reset && (state_q == S_DONE);

  assign accept = in_valid && in_ready;
  assign push   = accept && enc_ok;
  assign pop    = out_valid && out_ready;

  always_comb begin
    state_d      = state_q;
    wptr_d       = wptr_q;
    rptr_d       = rptr_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    err_d        = accept && !enc_ok;
    err_count_d  = err_count_q;
    word_count_d = word_count_q;

    if (push) wptr_d = wptr_q + 1'b1;
    if (pop) begin
      rptr_d       = rptr_q + 1'b1;
      addr_d       = addr_q + 32'd4;
      word_count_d = word_count_q + 16'd1;
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
    if (accept && !enc_ok) err_count_d = sat_inc8(err_count_q);

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d      = S_LOAD;
          addr_d       = BASE_ADDR;
          err_count_d  = 8'h0;
          word_count_d = 16'h0;
        end
      end
      S_LOAD:  if (accept && in_last) state_d = S_DRAIN;
      S_DRAIN: if (empty) state_d = S_DONE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= S_IDLE;
      wptr_q       <= '0;
      rptr_q       <= '0;
      cnt_q        <= '0;
      addr_q       <= BASE_ADDR;
      err_q        <= 1'b0;
      err_count_q  <= 8'h0;
      word_count_q <= 16'h0;
    end else begin
      state_q      <= state_d;
      wptr_q       <= wptr_d;
      rptr_q       <= rptr_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      err_q        <= err_d;
      err_count_q  <= err_count_d;
      word_count_q <= word_count_d;
    end
  end

  // FIFO storage carries data only; validity comes from cnt_q.
  always_ff @(posedge clk) begin
    if (push) mem[wptr_q] <= enc_word;
  end

endmodule

// File: tb/tb_instr_encoder.sv
module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        in_valid;
  logic        in_ready;
  logic        in_last;
  logic [6:0]  opcode;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [6:0]  funct7;
  logic [31:0] imm;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_addr;
  logic [31:0] out_data;
  logic        err;
  logic [7:0]  err_count;
  logic [15:0] word_count;
  logic        done;

  int tests = 0;
  int fails = 0;
  logic [63:0] sb [$];
  logic [31:0] exp_addr = 32'h0;

  instr_encoder #(.DEPTH(4), .BASE_ADDR(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .start(start),
    .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .opcode(opcode), .rd(rd), .rs1(rs1), .rs2(rs2),
    .funct3(funct3), .funct7(funct7), .imm(imm),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_addr(out_addr), .out_data(out_data),
    .err(err), .err_count(err_count), .word_count(word_count), .done(done)
  );

  always #5 clk = ~clk;

  // Monitor: every handshake that will complete on the next rising edge is
  // checked against the head of the scoreboard.
  always @(negedge clk) begin
    logic [63:0] e;
    if (!reset && out_valid && out_ready) begin
      tests++;
      if (sb.size() == 0) begin
        fails++;
        $display("FAIL unexpected_word: got addr=%h data=%h, required no word", out_addr, out_data);
      end else begin
        e = sb.pop_front();
        if (out_addr !== e[63:32] || out_data !== e[31:0]) begin
          fails++;
          $display("FAIL out_word: got addr=%h data=%h, required addr=%h data=%h",
                   out_addr, out_data, e[63:32], e[31:0]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, required %h", name, act, exp);
    end
  endtask

  task automatic do_start();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    exp_addr = 32'h0;
    check("in_ready_after_start", {31'h0, in_ready}, 32'h1);
  endtask

  task automatic send(input logic [6:0] op, input logic [4:0] f_rd, input logic [4:0] f_rs1,
                      input logic [4:0] f_rs2, input logic [2:0] f3, input logic [6:0] f7,
                      input logic [31:0] im, input logic last, input logic [31:0] exp_word,
                      input logic bad);
    bit got;
    opcode = op; rd = f_rd; rs1 = f_rs1; rs2 = f_rs2;
    funct3 = f3; funct7 = f7; imm = im; in_last = last;
    in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (in_ready) got = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!got) begin
      tests++; fails++;
      $display("FAIL accept_timeout: got no in_ready, required acceptance within 200 cycles");
    end else begin
      if (!bad) begin
        sb.push_back({exp_addr, exp_word});
        exp_addr += 32'd4;
      end
      check("err_after_tuple", {31'h0, err}, {31'h0, bad});
    end
  endtask

  task automatic wait_done(input logic [15:0] exp_wc, input logic [7:0] exp_ec);
    bit got;
    got = 1'b0;
    for (int i = 0; i < 200 && !got; i++) begin
      @(negedge clk);
      if (done) got = 1'b1;
      @(posedge clk); #1;
    end
    check("done_seen", {31'h0, got}, 32'h1);
    check("done_one_cycle", {31'h0, done}, 32'h0);
    check("word_count", {16'h0, word_count}, {16'h0, exp_wc});
    check("err_count", {24'h0, err_count}, {24'h0, exp_ec});
    check("scoreboard_drained", sb.size(), 32'h0);
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    opcode = '0; rd = '0; rs1 = '0; rs2 = '0; funct3 = '0; funct7 = '0; imm = '0;
    out_ready = 1'b0;

    // Reset state, during and after reset
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready",   {31'h0, in_ready},  32'h0);
    check("rst_out_valid",  {31'h0, out_valid}, 32'h0);
    check("rst_out_addr",   out_addr,           32'h0);
    check("rst_out_data",   out_data,           32'h0);
    check("rst_err",        {31'h0, err},       32'h0);
    check("rst_done",       {31'h0, done},      32'h0);
    check("rst_err_count",  {24'h0, err_count}, 32'h0);
    check("rst_word_count", {16'h0, word_count}, 32'h0);
    reset = 1'b0;
    @(posedge clk); #1;
    check("idle_in_ready",  {31'h0, in_ready},  32'h0);
    check("idle_out_valid", {31'h0, out_valid}, 32'h0);

    // in_valid outside LOAD is ignored (monitor flags any stray word)
    out_ready = 1'b1;
    opcode = 7'b0110011; rd = 5'd3; rs1 = 5'd1; rs2 = 5'd2; in_valid = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    check("idle_ignore_valid", {31'h0, out_valid}, 32'h0);

    // R-type single word
    do_start();
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b1, 32'h002081B3, 1'b0);
    wait_done(16'd1, 8'd0);

    // I-type with imm=-1, then LW
    do_start();
    send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFF, 1'b0, 32'hFFF00293, 1'b0);
    send(7'b0000011, 5'd6, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4,         1'b1, 32'h00412303, 1'b0);
    wait_done(16'd2, 8'd0);

    // SW with positive and negative immediates
    do_start();
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,         1'b0, 32'h0020A423, 1'b0);
    send(7'b0100011, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'hFFFF_FFFF, 1'b1, 32'hFE20AFA3, 1'b0);
    wait_done(16'd2, 8'd0);

    // Rejections: out-of-range immediate and unsupported opcode
    do_start();
    send(7'b0010011, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048, 1'b0, 32'h0, 1'b1);
    send(7'b1101111, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,    1'b1, 32'h0, 1'b1);
    wait_done(16'd0, 8'd2);

    // Back-pressure: four fill the FIFO, fifth waits for space
    out_ready = 1'b0;
    do_start();
    send(7'b0110011, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b0, 32'h002080B3, 1'b0);
    send(7'b0110011, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b0, 32'h00208133, 1'b0);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b0, 32'h002081B3, 1'b0);
    send(7'b0110011, 5'd4, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b0, 32'h00208233, 1'b0);
    @(negedge clk);
    check("full_in_ready",  {31'h0, in_ready},  32'h0);
    check("full_out_valid", {31'h0, out_valid}, 32'h1);
    check("full_out_addr",  out_addr,           32'h0);
    check("full_out_data",  out_data,           32'h002080B3);
    @(posedge clk); #1;
    out_ready = 1'b1;
    send(7'b0110011, 5'd5, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b1, 32'h002082B3, 1'b0);
    wait_done(16'd5, 8'd0);

    // Reset in DRAIN with three words buffered
    out_ready = 1'b0;
    do_start();
    send(7'b0110011, 5'd1, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b0, 32'h002080B3, 1'b0);
    send(7'b0110011, 5'd2, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b0, 32'h00208133, 1'b0);
    send(7'b0110011, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'h0, 1'b1, 32'h002081B3, 1'b0);
    check("drain_out_valid", {31'h0, out_valid}, 32'h1);
    reset = 1'b1;
    out_ready = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    check("post_rst_out_valid",  {31'h0, out_valid},  32'h0);
    check("post_rst_in_ready",   {31'h0, in_ready},   32'h0);
    check("post_rst_word_count", {16'h0, word_count}, 32'h0);
    check("post_rst_out_addr",   out_addr,            32'h0);
    @(posedge clk); #1;
    check("post_rst_idle_in_ready", {31'h0, in_ready}, 32'h0);
    do_start();
    send(7'b0000011, 5'd6, 5'd2, 5'd0, 3'd2, 7'd0, 32'd4, 1'b1, 32'h00412303, 1'b0);
    wait_done(16'd1, 8'd0);

    repeat (2) @(posedge clk);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 Parameter: DEPTH, 4, output FIFO entries (power of 2, >=2).
REQ-002 Parameter: BASE_ADDR, 32'h0000_0000, byte address assigned to the first emitted word after start.
REQ-003 clk  in  1  sole clock; all state updates on rising edge.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 start  in  1  one-cycle pulse; begins a load session, honoured only in IDLE.
REQ-006 in_valid  in  1  field tuple present.
REQ-007 in_ready  out  1  block accepts tuple this cycle.
REQ-008 in_last  in  1  tuple is final of session.
REQ-009 opcode  in  7  0110011 R-type, 0010011 I-type ALU, 0000011 LW, 0100011 SW.
REQ-010 rd / rs1 / rs2  in  5 each  register fields.
REQ-011 funct3  in  3; funct7  in  7; imm  in  32 (signed).
REQ-012 out_valid  out  1  encoded word present at FIFO head.
REQ-013 out_ready  in  1  consumer (instruction memory writer) takes word.
REQ-014 out_addr  out  32  byte address of head word; out_data  out  32  encoded instruction.
REQ-015 err  out  1  one-cycle pulse, cycle after a tuple is rejected.
REQ-016 err_count  out  8  saturating count of rejected tuples this session.
REQ-017 word_count  out  16  count of words handed off this session (wraps).
REQ-018 done  out  1  one-cycle pulse when session completes.

Function
REQ-019 FSM states SHALL be IDLE, LOAD, DRAIN, DONE.
REQ-020 IDLE->LOAD on start; on this transition addr counter<=BASE_ADDR, err_count<=0, word_count<=0.
REQ-021 LOAD->DRAIN on accepted tuple with in_last=1 (valid or rejected).
REQ-022 DRAIN->DONE when FIFO empty; DONE->IDLE unconditionally next cycle; done=1 only in DONE.
REQ-023 in_ready = (state==LOAD) && FIFO not full; full FIFO blocks input even if a pop occurs same cycle.
REQ-024 Tuple accepted iff in_valid && in_ready; in_valid while in_ready=0 ignored, no state change.
REQ-025 R-type encoding: {funct7, rs2, rs1, funct3, rd, opcode}.
REQ-026 I-type and LW encoding: {imm[11:0], rs1, funct3, rd, opcode}; rs2, funct7 ignored.
REQ-027 SW encoding: {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode}; rd, funct7 ignored.
REQ-028 For I/LW/SW, imm SHALL satisfy imm[31:11] all equal (range -2048..2047); R-type ignores imm.
REQ-029 Accepted tuple with unsupported opcode or out-of-range imm: not pushed, err=1 next cycle, err_count+1 saturating at 255.
REQ-030 Accepted valid tuple pushed same edge; out_valid earliest next cycle (latency 1).
REQ-031 Pop on out_valid && out_ready; addr counter +=4 (mod 2^32), word_count +1 on each pop.
REQ-032 out_addr = addr counter; out_data = head entry; both stable while out_valid && !out_ready.
REQ-033 Simultaneous push and pop with FIFO neither full nor empty: occupancy unchanged, order preserved.
REQ-034 start outside IDLE ignored; in_valid outside LOAD ignored.
REQ-035 FIFO read/write pointers wrap modulo DEPTH; no data corruption across wrap.

Reset
REQ-036 reset SHALL force IDLE, clear FIFO and pointers, addr counter<=BASE_ADDR, err_count=0, word_count=0.
REQ-037 During and after reset: in_ready=0, out_valid=0, out_addr=BASE_ADDR, out_data=0, err=0, done=0.
REQ-038 reset mid-LOAD or mid-DRAIN discards buffered words; no pop handshake completes in reset cycle.

Verification
REQ-039 start; R-type rd=3 rs1=1 rs2=2 f3=0 f7=0 last=1, out_ready=1 -> out_data 0x002081B3, out_addr 0x0, done after drain, word_count 1.
REQ-040 I-type rd=5 rs1=0 f3=0 imm=0xFFFFFFFF, then LW rd=6 rs1=2 f3=2 imm=4 -> 0xFFF00293 at 0x0, 0x00412303 at 0x4.
REQ-041 SW rs1=1 rs2=2 f3=2 imm=8 -> 0x0020A423; SW imm=-1 -> 0xFE20AFA3.
REQ-042 I-type imm=2048, then opcode 1101111 -> err pulses twice, no output words, err_count 2.
REQ-043 out_ready=0, offer 5 tuples -> 4 accepted, in_ready=0; out_ready=1 -> words at 0x0,0x4,0x8,0xC,0x10 in order, fifth accepted once space frees.
REQ-044 reset asserted in DRAIN with 3 words buffered -> next cycle out_valid=0, state IDLE, counters 0; new start begins at BASE_ADDR.
